// File: rtl/mux_sel_pkg.sv
// Shared constants for the RV32I write-back / ALU operand select unit.
package mux_sel_pkg;

  localparam int XLEN_DEF = 32;

  // Write-back source select codes
  localparam logic [2:0] WB_ALU        = 3'b000;
  localparam logic [2:0] WB_LU         = 3'b001;
  localparam logic [2:0] WB_IMM        = 3'b010;
  localparam logic [2:0] WB_IADDER_OUT = 3'b011;
  localparam logic [2:0] WB_CSR        = 3'b100;
  localparam logic [2:0] WB_PC_PLUS    = 3'b101;

  // ALU operand-2 select
  localparam logic ALU_SRC_RS2 = 1'b1;
  localparam logic ALU_SRC_IMM = 1'b0;

  // Codes above WB_PC_PLUS have no source behind them
  function automatic logic wb_sel_is_illegal(input logic [2:0] sel);
    return (sel > WB_PC_PLUS);
  endfunction

endpackage

// File: rtl/wb_sel_mux.sv
// Combinational 6:1 write-back source mux; unused codes yield zero.
module wb_sel_mux
  import mux_sel_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      sel_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] lu_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic [XLEN-1:0] csr_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  output logic [XLEN-1:0] data_out
);

  // Pick the source; zero default covers the two unused codes
  always_comb begin
    data_out = '0;
    case (sel_in)
      WB_ALU:        data_out = alu_in;
      WB_LU:         data_out = lu_in;
      WB_IMM:        data_out = imm_in;
      WB_IADDER_OUT: data_out = iadder_in;
      WB_CSR:        data_out = csr_in;
      WB_PC_PLUS:    data_out = pc_plus_4_in;
      default:       data_out = '0;
    endcase
  end

endmodule

// File: rtl/mux_sel_unit.sv
// Write-back data register and ALU operand-2 mux for the RV32I pipeline.
// Optional MUX_SEL_ILLEGAL_FLAG_EN adds a registered illegal-select flag.
module mux_sel_unit
  import mux_sel_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [2:0]      wb_mux_sel_reg_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] lu_output_in,
  input  logic [XLEN-1:0] imm_reg_in,
  input  logic [XLEN-1:0] iadder_out_reg_in,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic [XLEN-1:0] pc_plus_4_reg_in,
  input  logic [XLEN-1:0] rs2_reg_in,
  input  logic            alu_source_reg_in,
  output logic [XLEN-1:0] wb_mux_out,
  output logic [XLEN-1:0] alu_2nd_src_mux_out
`ifdef MUX_SEL_ILLEGAL_FLAG_EN
  ,
  output logic            wb_sel_illegal_out
`endif
);

  logic [XLEN-1:0] wb_sel_data;
  logic [XLEN-1:0] wb_mux_d, wb_mux_q;

  wb_sel_mux #(.XLEN(XLEN)) u_wb_sel_mux (
    .sel_in       (wb_mux_sel_reg_in),
    .alu_in       (alu_result_in),
    .lu_in        (lu_output_in),
    .imm_in       (imm_reg_in),
    .iadder_in    (iadder_out_reg_in),
    .csr_in       (csr_data_in),
    .pc_plus_4_in (pc_plus_4_reg_in),
    .data_out     (wb_sel_data)
  );

  // No stall/enable: the register reloads every cycle
  always_comb wb_mux_d = wb_sel_data;

  // Write-back register, cleared asynchronously by reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) wb_mux_q <= '0;
    else           wb_mux_q <= wb_mux_d;
  end

  assign wb_mux_out = wb_mux_q;

  // Operand-2 mux is pure combinational and ignores reset
  always_comb begin
    alu_2nd_src_mux_out = imm_reg_in;
    if (alu_source_reg_in == ALU_SRC_RS2) alu_2nd_src_mux_out = rs2_reg_in;
  end

`ifdef MUX_SEL_ILLEGAL_FLAG_EN
  logic sel_illegal_d, sel_illegal_q;

  // Flag tracks the legality of the code sampled at each edge
  always_comb sel_illegal_d = wb_sel_is_illegal(wb_mux_sel_reg_in);

  // Illegal-select flag register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) sel_illegal_q <= 1'b0;
    else           sel_illegal_q <= sel_illegal_d;
  end

  assign wb_sel_illegal_out = sel_illegal_q;
`else
  // Without the flag, illegal codes are visible only as zero write-back data
`endif

endmodule

// File: tb/tb_mux_sel_unit.sv
// Directed-vector bench for mux_sel_unit.
module tb_mux_sel_unit;

  localparam int XLEN = 32;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [2:0]      sel;
  logic [XLEN-1:0] alu, lu, imm, iadder, csr, pc4, rs2;
  logic            alu_src;
  logic [XLEN-1:0] wb_out, op2_out;
`ifdef MUX_SEL_ILLEGAL_FLAG_EN
  logic            ill_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  mux_sel_unit #(.XLEN(XLEN)) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .wb_mux_sel_reg_in   (sel),
    .alu_result_in       (alu),
    .lu_output_in        (lu),
    .imm_reg_in          (imm),
    .iadder_out_reg_in   (iadder),
    .csr_data_in         (csr),
    .pc_plus_4_reg_in    (pc4),
    .rs2_reg_in          (rs2),
    .alu_source_reg_in   (alu_src),
    .wb_mux_out          (wb_out),
    .alu_2nd_src_mux_out (op2_out)
`ifdef MUX_SEL_ILLEGAL_FLAG_EN
    ,
    .wb_sel_illegal_out  (ill_out)
`endif
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  logic [2:0]      sw_code [6] = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [XLEN-1:0] sw_exp  [6] = '{32'hAAAA0000, 32'h0000BEEF, 32'hC5C5C5C5,
                                   32'h00001004, 32'h0, 32'h0};

  initial begin
    rst_n_in = 1'b0;
    sel = 3'b000; alu = '0; lu = '0; imm = '0; iadder = '0;
    csr = '0; pc4 = '0; rs2 = '0; alu_src = 1'b0;

    // Reset held: output zero, operand mux still live
    #50;
    chk("rst_wb", wb_out, 32'h0);
`ifdef MUX_SEL_ILLEGAL_FLAG_EN
    chk("rst_flag", {31'b0, ill_out}, 32'h0);
`endif
    rs2 = 32'h12345678; imm = 32'h87654321; alu_src = 1'b1;
    #1 chk("op2_rs2_rst", op2_out, 32'h12345678);
    alu_src = 1'b0;
    #1 chk("op2_imm_rst", op2_out, 32'h87654321);
    rs2 = '0; imm = '0;

    // Release between edges; first edge loads select 000 (zero data)
    #48 rst_n_in = 1'b1;
    tick();
    chk("post_rel", wb_out, 32'h0);

    // WB_LU: not visible before the edge, visible after
    sel = 3'b001; lu = 32'h00000001;
    #1 chk("lu_pre", wb_out, 32'h0);
    tick();
    chk("lu", wb_out, 32'h00000001);

    // WB_IMM and operand mux selecting the immediate
    sel = 3'b010; imm = 32'h00000002; alu_src = 1'b0;
    #1 chk("op2_imm", op2_out, 32'h00000002);
    chk("imm_pre", wb_out, 32'h00000001);
    tick();
    chk("imm", wb_out, 32'h00000002);

    // Sweep remaining legal codes and both illegal codes
    alu = 32'hAAAA0000; iadder = 32'h0000BEEF; csr = 32'hC5C5C5C5; pc4 = 32'h00001004;
    for (int i = 0; i < 6; i++) begin
      sel = sw_code[i];
      tick();
      chk($sformatf("sweep_%0d", i), wb_out, sw_exp[i]);
`ifdef MUX_SEL_ILLEGAL_FLAG_EN
      chk($sformatf("flag_%0d", i), {31'b0, ill_out}, {31'b0, (i >= 4)});
`endif
    end

    // Back to a legal code: flag clears, output = iadder
    sel = 3'b011;
    tick();
    chk("iadder", wb_out, 32'h0000BEEF);
`ifdef MUX_SEL_ILLEGAL_FLAG_EN
    chk("flag_clr", {31'b0, ill_out}, 32'h0);
`endif

    // Operand mux toggle with zero delay
    rs2 = 32'h12345678; imm = 32'h87654321; alu_src = 1'b1;
    #0.5 chk("op2_rs2", op2_out, 32'h12345678);
    alu_src = 1'b0;
    #0.5 chk("op2_imm2", op2_out, 32'h87654321);

    // Mid-operation reset between edges
    #1 rst_n_in = 1'b0;
    #1 chk("mid_rst", wb_out, 32'h0);
    alu_src = 1'b1;
    #0.5 chk("op2_mid_rst", op2_out, 32'h12345678);
    tick();
    chk("mid_rst_e1", wb_out, 32'h0);
    tick();
    chk("mid_rst_e2", wb_out, 32'h0);

    // Release: next edge reloads iadder
    #2 rst_n_in = 1'b1;
    tick();
    chk("rel2", wb_out, 32'h0000BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
